nios2core_irqctrl: RTL and testbench
====================================

NIOS2CORE_IRQCTRL -- requirements
Module: nios2core_irqctrl

Interface
REQ-001 SHALL have parameter: NUM_IRQ, 8, number of interrupt inputs, legal range 1..16.
REQ-002 SHALL have port: clk  input  1  single clock; all logic is rising-edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: address  input  3  Avalon-MM slave word address.
REQ-005 SHALL have port: chipselect  input  1  slave select.
REQ-006 SHALL have port: write_n  input  1  active-low write strobe.
REQ-007 SHALL have port: writedata  input  16  write data.
REQ-008 SHALL have port: readdata  output  16  registered read data.
REQ-009 SHALL have port: irq_in  input  NUM_IRQ  level interrupt requests from peripherals, e.g. the system timer irq; same clock domain.
REQ-010 SHALL have port: irq_out  output  1  aggregated interrupt to the CPU, registered.

Function
REQ-011 SHALL define the write strobe for address A as chipselect && !write_n && address==A; reads have no side effects.
REQ-012 SHALL register irq_in into irq_q every cycle, and irq_q into irq_q2 every cycle.
REQ-013 SHALL hold a registered pending[NUM_IRQ-1:0] and per-bit mode[NUM_IRQ-1:0], where 0 = level and 1 = edge.
REQ-014 Level bit i: SHALL load pending[i] <= irq_q[i] every cycle; PENDING writes and SWI writes SHALL be ignored for that bit.
REQ-015 Edge bit i: set condition = (irq_q[i] && !irq_q2[i]) or an SWI write with writedata[i]=1; clear condition = a PENDING write with writedata[i]=1; set SHALL win when both occur in the same cycle; otherwise pending[i] SHALL hold.
REQ-016 Mode change SHALL NOT alter pending directly. After switching to level, pending follows irq_q from the next cycle. After switching to edge, the bit keeps its value until cleared.
REQ-017 SHALL register irq_out <= |(pending & enable) every cycle.
REQ-018 Latency: irq_in high before clock edge k gives irq_q=1 at k, pending=1 at k+1, irq_out=1 at k+2, in both modes.
REQ-019 SHALL compute active = lowest index i with pending[i] && enable[i], and valid = any such bit; index 0 has highest priority.
REQ-020 Register map, read value and write effect per address:
- 0 STATUS: reads irq_q zero-extended; read-only.
- 1 PENDING: reads pending; write is W1C for edge bits.
- 2 ENABLE: reads and writes enable[NUM_IRQ-1:0].
- 3 MODE: reads and writes mode[NUM_IRQ-1:0].
- 4 ACTIVE: reads {valid, 11'b0, active[3:0]}, with active=0 when valid=0; read-only.
- 5 SWI: reads 0; write sets edge-mode pending bits.
- 6, 7: read 0; writes ignored.
REQ-021 SHALL register readdata <= read mux of the current address every cycle, independent of chipselect, giving 1-cycle read latency. Register bits at or above NUM_IRQ SHALL read 0 and ignore writes.
REQ-022 ENABLE, MODE, PENDING and SWI writes SHALL take effect at the clock edge of the strobe. irq_out reflects a write to ENABLE one cycle later.

Reset
REQ-023 While reset=1, the block SHALL asynchronously clear irq_q, irq_q2, pending, enable, mode, readdata and irq_out to 0.
REQ-024 Reset asserted mid-operation SHALL drop irq_out to 0 immediately and lose all pending edges. After release, the block SHALL restart from the reset state, with a level input already high treated as a new rising edge on irq_q.

Verification
REQ-025 Level path: NUM_IRQ=8, ENABLE=0x01, MODE=0x00; raise irq_in[0] -> irq_out=1 two cycles later; drop it -> irq_out=0 two cycles later; a PENDING write of 0x01 while high has no effect.
REQ-026 Edge latch and W1C: MODE=0x04, ENABLE=0x04; pulse irq_in[2] for 1 cycle -> PENDING reads 0x04 and irq_out=1 until a PENDING write of 0x04, then irq_out=0 one cycle later.
REQ-027 Set/clear collision: edge bit 3 rising edge detected in the same cycle as a PENDING write of 0x08 -> pending[3] stays 1.
REQ-028 Priority: pending=0x0A, ENABLE=0x08 -> ACTIVE reads 0x8003; ENABLE=0x0A -> 0x8001; ENABLE=0x00 -> 0x0000 and irq_out=0.
REQ-029 SWI and reset: MODE=0xFF, ENABLE=0xFF, SWI write 0x80 -> PENDING=0x80, irq_out=1; assert reset mid-cycle -> irq_out and readdata 0 immediately; all registers read 0 after release.
REQ-030 Out-of-range: reads of addresses 6 and 7 return 0x0000; with NUM_IRQ=8, writing ENABLE=0xFFFF reads back 0x00FF.

Source files
------------

// File: rtl/nios2core_irqctrl.sv
`default_nettype none
// ============================================================================
// Module   : nios2core_irqctrl
// Purpose  : Interrupt controller for a Nios II style CPU on an Avalon-MM
//            slave port. Synchronises NUM_IRQ level requests, latches them as
//            per-bit level or edge pending flags, masks them with an enable
//            register and drives one registered aggregated irq to the CPU.
//            A priority encoder reports the lowest enabled pending source.
//
// Ports    : clk          rising-edge clock
//            reset        asynchronous active-high reset
//            address[2:0] word address (0 STATUS, 1 PENDING, 2 ENABLE,
//                         3 MODE, 4 ACTIVE, 5 SWI, 6/7 unused)
//            chipselect   slave select
//            write_n      active-low write strobe
//            writedata    16-bit write data
//            readdata     16-bit registered read data (1-cycle latency)
//            irq_in       level interrupt requests, same clock domain
//            irq_out      registered aggregated interrupt to the CPU
//
// Revision : 1.0  initial release
// ============================================================================
module nios2core_irqctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_PENDING = 3'd1;
    localparam logic [2:0] ADDR_ENABLE  = 3'd2;
    localparam logic [2:0] ADDR_MODE    = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
    localparam logic [2:0] ADDR_SWI     = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] irq_q2;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] enable_q;
    logic [NUM_IRQ-1:0] enable_d;
    logic [NUM_IRQ-1:0] mode_q;
    logic [NUM_IRQ-1:0] mode_d;
    logic [15:0]        readdata_q;
    logic [15:0]        readdata_d;
    logic               irq_out_q;
    logic               irq_out_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic               w_wr;
    logic               w_wr_pending;
    logic               w_wr_enable;
    logic               w_wr_mode;
    logic               w_wr_swi;
    logic [NUM_IRQ-1:0] w_wd;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic               w_valid;
    logic [3:0]         w_active;
    logic               w_unused_wd;

    assign w_wr         = chipselect && !write_n;
    assign w_wr_pending = w_wr && (address == ADDR_PENDING);
    assign w_wr_enable  = w_wr && (address == ADDR_ENABLE);
    assign w_wr_mode    = w_wr && (address == ADDR_MODE);
    assign w_wr_swi     = w_wr && (address == ADDR_SWI);

    // Register bits at or above NUM_IRQ do not exist; their write data is dropped.
    assign w_wd        = writedata[NUM_IRQ-1:0];
    assign w_unused_wd = &{1'b0, writedata};

    // Zero-extend an NUM_IRQ-wide vector onto the 16-bit read bus.
    function automatic logic [15:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [15:0] r;
        r              = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Pending update
    // Level bits mirror the synchronised input. Edge bits are set by a
    // rising edge on irq_q or a software interrupt, cleared by W1C; a set
    // in the same cycle as a clear wins so no edge is ever lost.
    // ------------------------------------------------------------------
    assign w_rise = irq_q & ~irq_q2;
    assign w_set  = w_rise | (w_wr_swi ? w_wd : '0);
    assign w_clr  = w_wr_pending ? w_wd : '0;

    always_comb begin
        pending_d = (mode_q & (w_set | (pending_q & ~w_clr)))
                  | (~mode_q & irq_q);
        enable_d  = w_wr_enable ? w_wd : enable_q;
        mode_d    = w_wr_mode   ? w_wd : mode_q;
        irq_out_d = |(pending_q & enable_q);
    end

    // ------------------------------------------------------------------
    // Priority encoder: scanning downward lets the lowest index overwrite.
    // ------------------------------------------------------------------
    always_comb begin
        w_valid  = 1'b0;
        w_active = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i] && enable_q[i]) begin
                w_valid  = 1'b1;
                w_active = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux, registered every cycle regardless of chipselect.
    // ------------------------------------------------------------------
    always_comb begin
        readdata_d = 16'h0000;
        case (address)
            ADDR_STATUS:  readdata_d = zext(irq_q);
            ADDR_PENDING: readdata_d = zext(pending_q);
            ADDR_ENABLE:  readdata_d = zext(enable_q);
            ADDR_MODE:    readdata_d = zext(mode_q);
            ADDR_ACTIVE:  readdata_d = {w_valid, 11'b0, w_active};
            default:      readdata_d = 16'h0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q      <= '0;
            irq_q2     <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            readdata_q <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            irq_q      <= irq_in;
            irq_q2     <= irq_q;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            readdata_q <= readdata_d;
            irq_out_q  <= irq_out_d;
        end
    end

    assign readdata = readdata_q;
    assign irq_out  = irq_out_q;

endmodule
`default_nettype wire

// File: tb/tb_nios2core_irqctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2core_irqctrl
// Purpose  : Self-checking bench for nios2core_irqctrl. A reference model
//            predicts readdata/irq_out for every cycle and queues them; a
//            monitor pops and compares each cycle. Directed sequences cover
//            the level, edge, collision, priority, SWI/reset and
//            out-of-range cases, followed by a randomized run.
// Revision : 1.0  initial release
// ============================================================================
module tb_nios2core_irqctrl;

    localparam int          N    = 8;
    localparam logic [15:0] MASK = 16'h00FF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    address = 3'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [15:0]   writedata = 16'h0;
    logic [15:0]   readdata;
    logic [N-1:0]  irq_in = '0;
    logic          irq_out;

    int n_cmp = 0;
    int n_err = 0;

    nios2core_irqctrl #(.NUM_IRQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_in     (irq_in),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: registers described by their architectural rules.
    // ------------------------------------------------------------------
    logic [15:0] m_q, m_q2, m_pend, m_en, m_mode;

    typedef struct packed {
        logic [15:0] rd;
        logic        irq;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [15:0] model_read(input int a);
        if (a == 0) return m_q;
        if (a == 1) return m_pend;
        if (a == 2) return m_en;
        if (a == 3) return m_mode;
        if (a == 4) begin
            for (int i = 0; i < N; i++)
                if (m_pend[i] && m_en[i]) return 16'h8000 | 16'(i);
            return 16'h0000;
        end
        return 16'h0000;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        logic [15:0] np;
        logic        wr;
        exp_t        e;
        if (reset) begin
            m_q    <= '0;
            m_q2   <= '0;
            m_pend <= '0;
            m_en   <= '0;
            m_mode <= '0;
            sb_q.delete();
        end else begin
            e.rd  = model_read(int'(address));
            e.irq = ((m_pend & m_en) != 16'h0);
            sb_q.push_back(e);
            wr = chipselect && !write_n;
            np = m_pend;
            for (int i = 0; i < N; i++) begin
                if (!m_mode[i])
                    np[i] = m_q[i];
                else if ((m_q[i] && !m_q2[i]) || (wr && address == 3'd5 && writedata[i]))
                    np[i] = 1'b1;
                else if (wr && address == 3'd1 && writedata[i])
                    np[i] = 1'b0;
            end
            m_pend <= np;
            if (wr && address == 3'd2) m_en   <= writedata & MASK;
            if (wr && address == 3'd3) m_mode <= writedata & MASK;
            m_q2 <= m_q;
            m_q  <= 16'(irq_in);
        end
    end

    // Monitor: every cycle the DUT presents fresh readdata/irq_out.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_readdata", readdata, e.rd);
            chk("sb_irq_out", {15'b0, irq_out}, {15'b0, e.irq});
        end
    end

    // ------------------------------------------------------------------
    // Bus tasks: inputs change just after the falling edge.
    // ------------------------------------------------------------------
    task automatic drive(input logic c, input logic w, input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        #1;
        chipselect = c;
        write_n    = w;
        address    = a;
        writedata  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 3'd0, 16'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        drive(1'b1, 1'b0, a, d);
    endtask

    task automatic read_chk(input logic [2:0] a, input logic [15:0] exp, input string nm);
        drive(1'b1, 1'b1, a, 16'h0);
        @(negedge clk);
        chk(nm, readdata, exp);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [2:0] ra;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 16'h0);
        chk("rst_irq_out", {15'b0, irq_out}, 16'h0);
        #1 reset = 1'b0;

        // Level path
        wr(3'd3, 16'h00);
        wr(3'd2, 16'h01);
        idle(); irq_in = 8'h01;
        repeat (3) idle();
        chk("lvl_irq_hi", {15'b0, irq_out}, 16'h1);
        wr(3'd1, 16'h01);
        read_chk(3'd1, 16'h0001, "lvl_w1c_ignored");
        chk("lvl_irq_still_hi", {15'b0, irq_out}, 16'h1);
        idle(); irq_in = 8'h00;
        repeat (3) idle();
        chk("lvl_irq_lo", {15'b0, irq_out}, 16'h0);

        // Edge latch and W1C
        wr(3'd3, 16'h04);
        wr(3'd2, 16'h04);
        idle(); irq_in = 8'h04;
        idle(); irq_in = 8'h00;
        repeat (3) idle();
        read_chk(3'd1, 16'h0004, "edge_pending");
        chk("edge_irq_hi", {15'b0, irq_out}, 16'h1);
        wr(3'd1, 16'h04);
        idle(); idle();
        chk("edge_irq_cleared", {15'b0, irq_out}, 16'h0);

        // Set/clear collision on edge bit 3
        wr(3'd3, 16'h08);
        wr(3'd2, 16'h08);
        idle(); irq_in = 8'h08;
        wr(3'd1, 16'h08);
        read_chk(3'd1, 16'h0008, "collision_set_wins");
        idle(); irq_in = 8'h00;

        // Priority
        wr(3'd3, 16'hFF);
        wr(3'd1, 16'hFF);
        wr(3'd5, 16'h0A);
        wr(3'd2, 16'h08);
        read_chk(3'd4, 16'h8003, "prio_en08");
        wr(3'd2, 16'h0A);
        read_chk(3'd4, 16'h8001, "prio_en0a");
        wr(3'd2, 16'h00);
        read_chk(3'd4, 16'h0000, "prio_en00");
        chk("prio_irq_lo", {15'b0, irq_out}, 16'h0);

        // SWI then asynchronous reset mid-cycle
        wr(3'd2, 16'hFF);
        wr(3'd1, 16'hFF);
        wr(3'd5, 16'h80);
        read_chk(3'd1, 16'h0080, "swi_pending");
        chk("swi_irq_hi", {15'b0, irq_out}, 16'h1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_readdata", readdata, 16'h0);
        chk("rst_async_irq_out", {15'b0, irq_out}, 16'h0);
        chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 16'h0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            ra = 3'(a);
            read_chk(ra, 16'h0000, "post_rst_zero");
        end

        // Out-of-range
        wr(3'd2, 16'hFFFF);
        read_chk(3'd2, 16'h00FF, "enable_width");
        wr(3'd6, 16'h1234);
        read_chk(3'd6, 16'h0000, "addr6_zero");
        read_chk(3'd7, 16'h0000, "addr7_zero");

        // Randomized run, with one reset while inputs are held high
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                irq_in = 8'hFF;
                @(posedge clk);
                #3 reset = 1'b1;
                repeat (2) @(negedge clk);
                #1 reset = 1'b0;
            end
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 16'($urandom));
            irq_in = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
        end
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
